aes_key_expansion: RTL
======================

Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule that produces the round keys r0..r10 consumed by AES_Encryption, which XORs r0 and feeds r1..r10 to its doRound/lastRound instances.
- Latches one 128-bit cipher key and computes one round key per clock into an internal bank.
- Presents all 11 round keys as a flat bus with a ready flag, so the encryption datapath only starts once the schedule is complete.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a synthesis-time error.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  start request; sampled only while busy=0.
- key_in  in  128  cipher key; byte 0 is key_in[127:120]; w0 is key_in[127:96].
- busy  out  1  high while expansion is in progress.
- keys_ready  out  1  high when round_keys holds a complete schedule for the last accepted key.
- round_keys  out  1408  round key i is at [128*i+127 : 128*i]; i=0 is the cipher key, i=10 is the final round key.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, keys_ready=0, round counter=0, all 11 bank entries = 0. The effect is immediate and does not wait for an edge.
- States: IDLE, EXPAND.
- IDLE, with key_valid=1 at an edge:
  - bank[0] <= key_in, counter <= 1, busy <= 1, keys_ready <= 0.
  - Go to EXPAND.
  - Bank entries 1..10 keep their stale values until overwritten.
- IDLE, with key_valid=0: hold all state.
- EXPAND, each edge:
  - Take prev = bank[counter-1], split into words w0..w3 (w0 = bits [127:96]).
  - t = SubWord(RotWord(w3)) ^ {Rcon[counter], 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - bank[counter] <= {n0,n1,n2,n3}, counter <= counter+1.
- EXPAND, on the edge that writes bank[10]:
  - busy <= 0, keys_ready <= 1, counter <= 0.
  - Go to IDLE.
- RotWord: {b1,b2,b3,b0} of w3 = {b0,b1,b2,b3}. SubWord applies the AES S-box to each byte. The S-box path is combinational within the cycle.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Latency:
  - The accept edge is E0. bank[k] is written at edge Ek.
  - keys_ready rises at E10: 10 cycles after acceptance, 11 edges including the accept edge.
  - Throughput is one key per 11 cycles.
- key_valid while busy=1: ignored. No queueing and no error flag. key_in changes during EXPAND have no effect.
- key_valid while keys_ready=1: accepted as a new start. keys_ready drops at that accept edge. Consumers must not sample round_keys while keys_ready=0.
- keys_ready stays high indefinitely until the next accepted start or reset.
- key_valid held high continuously: a new expansion starts on every IDLE edge. The schedule completes and keys_ready pulses high for exactly one cycle, coincident with the IDLE cycle in which the next start is accepted. This is legal behaviour.
- round_keys is a direct register output with no combinational path from inputs.
- Reset asserted mid-EXPAND: everything clears as in reset. After release, the block idles until a new key_valid.

Decomposition:
- Package aes_pkg holds:
  - AES_NR=10, AES_NK=4, round-key width 128, word width 32.
  - The Rcon table as a 10-entry constant function/array.
  - Round-key bus index helper (offset = 128*i).
- Sub-module aes_sbox: combinational 8-bit lookup, no clock. Four instances form SubWord. The same module is reused by doRound/lastRound SubBytes.
- The FSM, counter and bank stay in aes_key_expansion (~200 lines).

Test Plan:
- FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, key_valid for 1 cycle -> busy=1 for 10 cycles. At keys_ready:
  - rk1=a0fafe1788542cb123a339392a6c7605
  - rk2=f2c295f27a96b9435935807a7359f67f
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6
  - rk0 equals key_in.
- All-zero key -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e. keys_ready rises exactly 10 cycles after the accept edge.
- key_valid re-asserted with a different key at cycles 3 and 7 of an expansion -> both ignored. The result equals the first key's schedule and busy deasserts on schedule.
- Back-to-back: run A.1, then while keys_ready=1 start with the zero key -> keys_ready falls at the accept edge and the final bank equals the zero-key schedule.
- rst_n pulsed low at cycle 5 of EXPAND, asynchronously mid-cycle -> busy=0, keys_ready=0 and round_keys=0 immediately. A new A.1 start after release yields the correct schedule.
- Power-on: no key_valid for 50 cycles after reset -> busy=0, keys_ready=0, round_keys=0 throughout.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule constants, state encoding,
//               round-constant lookup and round-key bus offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int unsigned AES_NR     = 10;   // rounds for AES-128
    localparam int unsigned AES_NK     = 4;    // 32-bit words per key
    localparam int unsigned AES_RK_W   = 128;  // round-key width
    localparam int unsigned AES_WORD_W = 32;   // schedule word width

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ke_state_t;

    // Round constant for rounds 1..10; other indices never occur.
    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] rc;
        rc = 8'h00;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Bit offset of round key i within the flat round-key bus.
    function automatic int unsigned rk_offset(input int unsigned i);
        return AES_RK_W * i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (8-bit lookup, no clock).
// Ports       : data_in  - input byte
//               data_out - substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_out = SBOX_TABLE[data_in];

endmodule
`default_nettype wire

// File: rtl/aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expansion
// Description : Iterative AES-128 key schedule. Latches a cipher key and
//               derives one round key per clock into an 11-entry bank, then
//               flags the complete schedule with keys_ready.
// Ports       : clk        - system clock (rising edge)
//               rst_n      - asynchronous active-low reset
//               key_valid  - start request, honoured only while idle
//               key_in     - 128-bit cipher key (w0 = key_in[127:96])
//               busy       - expansion in progress
//               keys_ready - round_keys holds a full schedule
//               round_keys - key i at [128*i +: 128], i = 0..10
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_valid,
    input  logic [AES_RK_W-1:0]         key_in,
    output logic                        busy,
    output logic                        keys_ready,
    output logic [(NR+1)*AES_RK_W-1:0]  round_keys
);

    generate
        if (NR != AES_NR) begin : g_nr_check
            $error("aes_key_expansion supports only NR = 10 (AES-128)");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ke_state_t              r_state;
    ke_state_t              w_state_next;
    logic [3:0]             r_counter;
    logic                   r_busy;
    logic                   r_keys_ready;
    logic [AES_RK_W-1:0]    r_bank [0:NR];

    logic [3:0]             w_prev_idx;
    logic [AES_RK_W-1:0]    w_prev;
    logic [AES_WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
    logic [AES_WORD_W-1:0]  w_rot;
    logic [AES_WORD_W-1:0]  w_sub;
    logic [AES_WORD_W-1:0]  w_t;
    logic [AES_WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;

    // Counter is 0 only in IDLE, where the schedule result is unused;
    // clamping keeps the bank read in range.
    assign w_prev_idx = (r_counter == 4'd0) ? 4'd0 : (r_counter - 4'd1);
    assign w_prev     = r_bank[w_prev_idx];

    assign w_w0 = w_prev[127:96];
    assign w_w1 = w_prev[95:64];
    assign w_w2 = w_prev[63:32];
    assign w_w3 = w_prev[31:0];

    // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .data_in  (w_rot[8*gi +: 8]),
                .data_out (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {aes_rcon(r_counter), 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (key_valid) begin
                    w_state_next = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (r_counter == LAST_ROUND) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, flags and round-key bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter    <= 4'd0;
            r_busy       <= 1'b0;
            r_keys_ready <= 1'b0;
            for (int i = 0; i <= int'(NR); i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        // Entries 1..NR stay stale until rewritten.
                        r_bank[0]    <= key_in;
                        r_counter    <= 4'd1;
                        r_busy       <= 1'b1;
                        r_keys_ready <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    r_bank[r_counter] <= {w_n0, w_n1, w_n2, w_n3};
                    if (r_counter == LAST_ROUND) begin
                        r_counter    <= 4'd0;
                        r_busy       <= 1'b0;
                        r_keys_ready <= 1'b1;
                    end else begin
                        r_counter <= r_counter + 4'd1;
                    end
                end
                default: begin
                    r_counter <= 4'd0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign keys_ready = r_keys_ready;

    generate
        for (genvar gk = 0; gk <= int'(NR); gk++) begin : g_flat
            assign round_keys[rk_offset(gk) +: AES_RK_W] = r_bank[gk];
        end
    endgenerate

endmodule
`default_nettype wire
